// File: rtl/corr_score_engine.sv
// Template correlation engine: raster-scans a TPL_W x TPL_H window, scoring similarity or SAD.
// Result TPL_W*TPL_H+RD_LAT+1 cycles after start; new starts are ignored while busy, and a SAD run stops early past its threshold.
module corr_score_engine #(
  parameter int PIX_W   = 10,
  parameter int COORD_W = 13,
  parameter int TPL_W   = 64,
  parameter int TPL_H   = 48,
  parameter int RD_LAT  = 2,
  parameter int SCORE_W = 32
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic [COORD_W-1:0] iXstart,
  input  logic [COORD_W-1:0] iYstart,
  input  logic               iMode,
  input  logic [SCORE_W-1:0] iAbortThr,
  output logic [COORD_W-1:0] oX_sram,
  output logic [COORD_W-1:0] oY_sram,
  output logic [COORD_W-1:0] oX_tpl,
  output logic [COORD_W-1:0] oY_tpl,
  input  logic [PIX_W-1:0]   reading_sram,
  input  logic [PIX_W-1:0]   reading_tpl,
  output logic               oBusy,
  output logic               oDone,
  output logic               oAborted,
  output logic [SCORE_W-1:0] oScore
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(TPL_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(TPL_H - 1);
  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
  localparam logic [PIX_W-1:0]   PIX_MAX   = '1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state_q;
  logic [COORD_W-1:0] x_q, y_q, xs_q, ys_q;
  logic               mode_q;
  logic [SCORE_W-1:0] thr_q, acc_q, score_q;
  logic [RD_LAT-1:0]  vld_q, vld_d;
  logic               busy_q, done_q, aborted_q;

  logic               scan, last_idx, term_vld, abort_hit;
  logic [PIX_W-1:0]   diff, term;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] acc_d;

  assign scan      = (state_q == SCAN);
  assign last_idx  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign term_vld  = vld_q[RD_LAT-1];
  assign diff      = (reading_sram >= reading_tpl) ? reading_sram - reading_tpl
                                                   : reading_tpl - reading_sram;
  assign term      = mode_q ? diff : PIX_MAX - diff;
  assign sum       = {1'b0, acc_q} + (SCORE_W+1)'(term);
  assign acc_d     = sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  // Checked against the already-updated accumulator, so the abort lands one edge after the crossing term.
  assign abort_hit = mode_q && (thr_q != '0) && (acc_q > thr_q) &&
                     ((state_q == SCAN) || (state_q == DRAIN));

  always_comb begin
    vld_d    = '0;
    vld_d[0] = scan && !abort_hit;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      xs_q      <= '0;
      ys_q      <= '0;
      mode_q    <= 1'b0;
      thr_q     <= '0;
      acc_q     <= '0;
      score_q   <= '0;
      vld_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      vld_q  <= vld_d;
      case (state_q)
        IDLE: begin
          if (iStart) begin
            state_q   <= SCAN;
            xs_q      <= iXstart;
            ys_q      <= iYstart;
            mode_q    <= iMode;
            thr_q     <= iAbortThr;
            acc_q     <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
          end
        end
        SCAN, DRAIN: begin
          if (abort_hit) begin
            state_q   <= DONE;
            vld_q     <= '0;
            aborted_q <= 1'b1;
            score_q   <= acc_q;
            done_q    <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
          end else begin
            if (term_vld) acc_q <= acc_d;
            if (state_q == SCAN) begin
              if (last_idx) begin
                state_q <= DRAIN;
                x_q     <= '0;
                y_q     <= '0;
              end else if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + COORD_ONE;
              end else begin
                x_q <= x_q + COORD_ONE;
              end
            end else if (vld_q == '0) begin
              state_q <= DONE;
              score_q <= acc_q;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oX_tpl   = scan ? x_q : '0;
  assign oY_tpl   = scan ? y_q : '0;
  assign oX_sram  = scan ? xs_q + x_q : '0;
  assign oY_sram  = scan ? ys_q + y_q : '0;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oAborted = aborted_q;
  assign oScore   = score_q;

endmodule

// File: tb/tb_corr_score_engine.sv
// Bench for corr_score_engine: 4x2 template, RD_LAT=2, plus a 12-bit-score instance for saturation.
module tb_corr_score_engine;
  localparam int PIX_W = 10, COORD_W = 13, TPL_W = 4, TPL_H = 2, RD_LAT = 2;
  localparam int SCORE_W = 32, SAT_W = 12;
  localparam int N = TPL_W * TPL_H;
  localparam int DREL = N + RD_LAT + 1;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, mode = 1'b0;
  logic [COORD_W-1:0] xs = '0, ys = '0;
  logic [SCORE_W-1:0] thr = '0;
  logic [SAT_W-1:0]   sthr;
  logic [COORD_W-1:0] x_sram, y_sram, x_tpl, y_tpl;
  logic [COORD_W-1:0] sx_sram, sy_sram, sx_tpl, sy_tpl;
  logic [PIX_W-1:0]   rd_sram, rd_tpl, p1_s, p1_t;
  logic busy, done, aborted, sbusy, sdone, saborted;
  logic [SCORE_W-1:0] score;
  logic [SAT_W-1:0]   sscore;

  assign sthr = thr[SAT_W-1:0];

  corr_score_engine #(.PIX_W(PIX_W), .COORD_W(COORD_W), .TPL_W(TPL_W), .TPL_H(TPL_H),
                      .RD_LAT(RD_LAT), .SCORE_W(SCORE_W)) u_dut (
    .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iXstart(xs), .iYstart(ys), .iMode(mode),
    .iAbortThr(thr), .oX_sram(x_sram), .oY_sram(y_sram), .oX_tpl(x_tpl), .oY_tpl(y_tpl),
    .reading_sram(rd_sram), .reading_tpl(rd_tpl), .oBusy(busy), .oDone(done),
    .oAborted(aborted), .oScore(score));

  corr_score_engine #(.PIX_W(PIX_W), .COORD_W(COORD_W), .TPL_W(TPL_W), .TPL_H(TPL_H),
                      .RD_LAT(RD_LAT), .SCORE_W(SAT_W)) u_sat (
    .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iXstart(xs), .iYstart(ys), .iMode(mode),
    .iAbortThr(sthr), .oX_sram(sx_sram), .oY_sram(sy_sram), .oX_tpl(sx_tpl), .oY_tpl(sy_tpl),
    .reading_sram(rd_sram), .reading_tpl(rd_tpl), .oBusy(sbusy), .oDone(sdone),
    .oAborted(saborted), .oScore(sscore));

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Memory models: frame is a hash of coordinates (or a constant), template is a small array.
  logic [PIX_W-1:0] tpl_mem [TPL_H][TPL_W];
  bit               const_pat = 1'b1;
  logic [PIX_W-1:0] fconst = '0;
  int               seed = 0;

  function automatic logic [PIX_W-1:0] fpix(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    if (const_pat) return fconst;
    return PIX_W'((int'(x) * 131 + int'(y) * 977 + seed) % 1024);
  endfunction

  always @(posedge clk) begin
    p1_s    <= fpix(x_sram, y_sram);
    p1_t    <= tpl_mem[y_tpl[0]][x_tpl[1:0]];
    rd_sram <= p1_s;
    rd_tpl  <= p1_t;
  end

  function automatic void model(input logic m, input logic [SCORE_W-1:0] th,
                                input logic [COORD_W-1:0] x0, input logic [COORD_W-1:0] y0,
                                input longint maxv, output longint sc, output bit ab, output int drel);
    longint acc;
    int x, y, sp, tp, d;
    acc = 0; ab = 1'b0; drel = DREL;
    for (int k = 0; k < N; k++) begin
      x  = k % TPL_W;
      y  = k / TPL_W;
      sp = int'(fpix(COORD_W'(int'(x0) + x), COORD_W'(int'(y0) + y)));
      tp = int'(tpl_mem[y][x]);
      d  = (sp > tp) ? sp - tp : tp - sp;
      acc = acc + (m ? d : 1023 - d);
      if (acc > maxv) acc = maxv;
      if (m && th != 0 && acc > longint'(th)) begin
        ab = 1'b1; drel = k + RD_LAT + 2; break;
      end
    end
    sc = acc;
  endfunction

  int checks = 0, failures = 0;
  int done_cnt, done_rel, s_edge;
  logic [SCORE_W-1:0] got_sc;
  logic [SAT_W-1:0]   got_ssc;
  logic got_ab, got_sab;
  logic [COORD_W-1:0] cap_xs [32], cap_ys [32], cap_xt [32], cap_yt [32];
  logic cap_busy [32], cap_ab [32];

  task automatic fill_tpl(input bit equal);
    for (int y = 0; y < TPL_H; y++)
      for (int x = 0; x < TPL_W; x++)
        tpl_mem[y][x] = equal ? fconst : PIX_W'($urandom_range(0, 1023));
  endtask

  task automatic run(input logic m, input logic [SCORE_W-1:0] th,
                     input logic [COORD_W-1:0] x0, input logic [COORD_W-1:0] y0, input bit poke);
    @(negedge clk);
    start = 1'b1; mode = m; thr = th; xs = x0; ys = y0;
    @(posedge clk); #1;
    s_edge = edge_cnt;
    start = 1'b0; mode = ~m; thr = $urandom; xs = COORD_W'($urandom); ys = COORD_W'($urandom);
    done_cnt = 0; done_rel = -1; got_sc = '0; got_ssc = '0; got_ab = 1'b0; got_sab = 1'b0;
    for (int r = 0; r < 24; r++) begin
      @(negedge clk);
      cap_xs[r] = x_sram; cap_ys[r] = y_sram; cap_xt[r] = x_tpl; cap_yt[r] = y_tpl;
      cap_busy[r] = busy; cap_ab[r] = aborted;
      if (done) begin done_cnt++; done_rel = edge_cnt - s_edge; got_sc = score; got_ab = aborted; end
      if (sdone) begin got_ssc = sscore; got_sab = saborted; end
      start = poke && (r == 1 || r == 3 || r == N + 1 || r == DREL);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL reset_aborted got=%0b exp=0", aborted); end
    checks++; if (score !== '0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++; if ({x_sram, y_sram, x_tpl, y_tpl} !== '0)
      begin failures++; $display("FAIL reset_coords got=%0d,%0d,%0d,%0d exp=0", x_sram, y_sram, x_tpl, y_tpl); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_equal;
    const_pat = 1'b1; fconst = PIX_W'($urandom_range(0, 1023)); fill_tpl(1'b1);
    run(1'b0, 32'd100, COORD_W'($urandom), COORD_W'($urandom), 1'b0);
    checks++; if (got_sc !== 32'd8184) begin failures++; $display("FAIL equal_score got=%0d exp=8184", got_sc); end
    checks++; if (done_rel !== DREL) begin failures++; $display("FAIL equal_done_edge got=%0d exp=%0d", done_rel, DREL); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL equal_done_count got=%0d exp=1", done_cnt); end
    checks++; if (got_ab !== 1'b0) begin failures++; $display("FAIL equal_aborted got=%0b exp=0", got_ab); end
    checks++; if (got_ssc !== 12'd4095) begin failures++; $display("FAIL equal_saturate got=%0d exp=4095", got_ssc); end
    checks++; if ({cap_busy[0], cap_busy[DREL], cap_busy[DREL+1]} !== 3'b110)
      begin failures++; $display("FAIL equal_busy got=%b exp=110", {cap_busy[0], cap_busy[DREL], cap_busy[DREL+1]}); end
    checks++; if (score !== 32'd8184) begin failures++; $display("FAIL equal_hold got=%0d exp=8184", score); end
  endtask

  task automatic test_extremes;
    const_pat = 1'b1; fconst = 10'd1023; fill_tpl(1'b1); fconst = 10'd1023;
    for (int y = 0; y < TPL_H; y++) for (int x = 0; x < TPL_W; x++) tpl_mem[y][x] = '0;
    run(1'b0, 32'd0, 13'd10, 13'd20, 1'b0);
    checks++; if (got_sc !== 32'd0) begin failures++; $display("FAIL extreme_mode0 got=%0d exp=0", got_sc); end
    fconst = 10'd505;
    for (int y = 0; y < TPL_H; y++) for (int x = 0; x < TPL_W; x++) tpl_mem[y][x] = 10'd500;
    run(1'b1, 32'd0, 13'd3, 13'd4, 1'b0);
    checks++; if (got_sc !== 32'd40) begin failures++; $display("FAIL sad_noabort got=%0d exp=40", got_sc); end
    checks++; if (got_ab !== 1'b0) begin failures++; $display("FAIL sad_noabort_flag got=%0b exp=0", got_ab); end
  endtask

  task automatic test_abort;
    const_pat = 1'b1; fconst = 10'd505;
    for (int y = 0; y < TPL_H; y++) for (int x = 0; x < TPL_W; x++) tpl_mem[y][x] = 10'd500;
    run(1'b1, 32'd20, 13'd0, 13'd0, 1'b0);
    checks++; if (got_sc !== 32'd25) begin failures++; $display("FAIL abort_score got=%0d exp=25", got_sc); end
    checks++; if (got_ab !== 1'b1) begin failures++; $display("FAIL abort_flag got=%0b exp=1", got_ab); end
    checks++; if (done_rel !== 8) begin failures++; $display("FAIL abort_done_edge got=%0d exp=8", done_rel); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL abort_done_count got=%0d exp=1", done_cnt); end
    checks++; if ({score, aborted} !== {32'd25, 1'b1})
      begin failures++; $display("FAIL abort_hold got=%0d/%0b exp=25/1", score, aborted); end
    checks++; if ({got_ssc, got_sab} !== {12'd25, 1'b1})
      begin failures++; $display("FAIL abort_sat got=%0d/%0b exp=25/1", got_ssc, got_sab); end
  endtask

  task automatic test_wrap;
    longint esc; bit eab; int edr;
    logic [COORD_W-1:0] ex;
    const_pat = 1'b0; seed = $urandom_range(0, 5000); fill_tpl(1'b0);
    model(1'b0, 32'd0, 13'd8190, 13'd0, 64'hFFFF_FFFF, esc, eab, edr);
    run(1'b0, 32'd0, 13'd8190, 13'd0, 1'b1);
    checks++; if (cap_ab[0] !== 1'b0) begin failures++; $display("FAIL wrap_abort_cleared got=%0b exp=0", cap_ab[0]); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL wrap_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_rel !== edr) begin failures++; $display("FAIL wrap_done_edge got=%0d exp=%0d", done_rel, edr); end
    checks++; if (got_sc !== 32'(esc)) begin failures++; $display("FAIL wrap_score got=%0d exp=%0d", got_sc, esc); end
    for (int r = 0; r < N; r++) begin
      ex = COORD_W'(8190 + r % TPL_W);
      checks++;
      if ({cap_xs[r], cap_ys[r], cap_xt[r], cap_yt[r]} !==
          {ex, COORD_W'(r / TPL_W), COORD_W'(r % TPL_W), COORD_W'(r / TPL_W)}) begin
        failures++;
        $display("FAIL wrap_coord[%0d] got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d", r, cap_xs[r], cap_ys[r],
                 cap_xt[r], cap_yt[r], ex, r / TPL_W, r % TPL_W, r / TPL_W);
      end
    end
    checks++; if ({cap_xs[N], cap_ys[N], cap_xt[N], cap_yt[N]} !== '0)
      begin failures++; $display("FAIL wrap_coord_after got=%0d,%0d exp=0,0", cap_xs[N], cap_xt[N]); end
  endtask

  task automatic test_random;
    longint esc, essc; bit eab, esab; int edr, esdr;
    logic m; logic [SCORE_W-1:0] th; logic [COORD_W-1:0] x0, y0;
    for (int i = 0; i < 8; i++) begin
      const_pat = 1'b0; seed = $urandom_range(0, 100000); fill_tpl(1'b0);
      m  = 1'($urandom_range(0, 1));
      th = m ? ($urandom_range(0, 3) == 0 ? 32'd0 : 32'($urandom_range(1, 6000))) : $urandom;
      x0 = COORD_W'($urandom); y0 = COORD_W'($urandom);
      model(m, th, x0, y0, 64'hFFFF_FFFF, esc, eab, edr);
      model(m, th & 32'hFFF, x0, y0, 64'd4095, essc, esab, esdr);
      run(m, th, x0, y0, 1'b0);
      checks++; if ({got_sc, got_ab} !== {32'(esc), eab}) begin failures++;
        $display("FAIL rand%0d_score got=%0d/%0b exp=%0d/%0b", i, got_sc, got_ab, esc, eab); end
      checks++; if (done_rel !== edr || done_cnt !== 1) begin failures++;
        $display("FAIL rand%0d_done got=edge%0d/cnt%0d exp=edge%0d/cnt1", i, done_rel, done_cnt, edr); end
      checks++; if ({got_ssc, got_sab} !== {SAT_W'(essc), esab}) begin failures++;
        $display("FAIL rand%0d_sat got=%0d/%0b exp=%0d/%0b", i, got_ssc, got_sab, essc, esab); end
    end
  endtask

  task automatic test_reset_mid;
    int dc;
    const_pat = 1'b1; fconst = 10'd321; fill_tpl(1'b1);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; thr = '0; xs = 13'd5; ys = 13'd6;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; #1;
    checks++; if ({busy, done, aborted} !== 3'b000)
      begin failures++; $display("FAIL midrst_flags got=%b exp=000", {busy, done, aborted}); end
    checks++; if (score !== '0) begin failures++; $display("FAIL midrst_score got=%0d exp=0", score); end
    checks++; if ({x_sram, y_sram, x_tpl, y_tpl} !== '0)
      begin failures++; $display("FAIL midrst_coords got=%0d,%0d exp=0,0", x_sram, x_tpl); end
    @(negedge clk); rst_n = 1'b1;
    dc = 0;
    repeat (20) begin @(negedge clk); if (done) dc++; end
    checks++; if (dc !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dc); end
    run(1'b0, 32'd0, 13'd7, 13'd8, 1'b0);
    checks++; if (got_sc !== 32'd8184 || done_rel !== DREL || done_cnt !== 1) begin failures++;
      $display("FAIL midrst_restart got=%0d/edge%0d/cnt%0d exp=8184/edge%0d/cnt1", got_sc, done_rel, done_cnt, DREL); end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_extremes();
    test_abort();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
